au_add_mp_seq: RTL
==================

# au_add_mp_seq

Multi-precision sequenced adder. It adds two signed (2's complement) operands of NWORD×WIDTH bits over NWORD cycles by time-sharing one WIDTH-bit slice adder, least significant slice first. Carry is propagated between slices through a register. It reports the full-width 2's complement overflow flag. It sits between a requester using a valid/ready handshake and wide-operand consumers, replacing a wide combinational adder where area matters more than latency.

## Interface
- WIDTH, 8, slice word length (>= 1)
- NWORD, 4, number of slices per operand (>= 2)
- ARCH, 0, slice adder architecture (0 to 2), passed through to the slice
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- a  input  NWORD*WIDTH  augend, signed
- b  input  NWORD*WIDTH  addend, signed
- ci  input  1  carry-in into slice 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- s  output  NWORD*WIDTH  sum, registered
- v  output  1  2's complement overflow of the full-width sum, registered

## Operation
- States:
  - IDLE: in_ready=1.
  - BUSY: slices in progress.
  - DONE: out_valid=1.
- IDLE -> BUSY on in_valid & in_ready:
  - Latch a, b and ci into operand registers.
  - Set idx=0 and the carry register to ci.
  - After acceptance, inputs may change freely.
- BUSY cycle idx:
  - The slice computes a[idx], b[idx] plus the carry register.
  - On the clock edge: store the result in sum slice idx, store the slice carry-out in the carry register, idx++.
- On the edge where idx==NWORD-1:
  - Store the slice's signed overflow (carry into MSB xor carry out) into v.
  - Go to DONE.
- DONE -> IDLE on out_ready. s and v hold their values until the next result is written.
- Arithmetic:
  - s equals (a + b + ci) mod 2^(NWORD*WIDTH).
  - v=1 exactly when the signed sum lies outside the range [-2^(N-1), 2^(N-1)-1], where N=NWORD*WIDTH.
- in_valid is ignored in BUSY and DONE. A request is held off by in_ready=0, never dropped.
- s, v and out_valid change only on state edges and never glitch combinationally.

## Timing
- Reset values: in_ready=1, out_valid=0, s=0, v=0, state IDLE, idx=0, carry=0.
- Latency: out_valid rises NWORD clock edges after the accepting edge.
- Throughput: one request every NWORD+2 cycles at best. The sequence is accept, NWORD BUSY cycles, DONE with out_ready high, then IDLE.
- Handshake:
  - Transfer occurs on the edge where valid & ready are both high.
  - out_valid stays high, with s and v stable, until out_ready is sampled high.
- out_ready high before out_valid has no effect.
- rst asserted in any state forces reset values immediately, with no clock needed. Any partial sum is discarded.
- idx wraps only via the state transition; it never counts past NWORD-1.

## Configuration
- AU_ADD_MP_SEQ_SAT_EN defined:
  - On the DONE entry edge, if overflow occurred, s is loaded with the saturated value instead of the wrapped sum.
  - Saturated value: 2^(N-1)-1 when the latched a MSB is 0, otherwise -2^(N-1).
  - v still reports 1.
- Not defined: s is always the wrapped sum, and no saturation logic is present.

## Structure
- Package au_add_mp_pkg holds:
  - State enum (IDLE, BUSY, DONE).
  - idx width function: clog2 of NWORD, minimum 1.
  - Parameter legality check values: WIDTH >= 1, NWORD >= 2, ARCH 0..2. An illegal value aborts simulation with an error message.
- Sub-module au_add_mp_slice:
  - Combinational WIDTH-bit adder with ports a, b, ci, s, co and v.
  - ARCH selects the parallel-prefix carry-lookahead architecture.
  - Instantiated once; no other arithmetic in the top.

## Test plan (WIDTH=8, NWORD=4)
- a=0x000000FF, b=0x00000001, ci=0 -> s=0x00000100, v=0; out_valid exactly 4 edges after accept; slice carry crosses.
- a=0x7FFFFFFF, b=0, ci=1 -> s=0x80000000, v=1; with SAT_EN, s=0x7FFFFFFF.
- a=0x80000000, b=0xFFFFFFFF, ci=0 -> s=0x7FFFFFFF, v=1; with SAT_EN, s=0x80000000.
- a=0xFFFFFFFF, b=0x00000001, ci=0 -> s=0x00000000, v=0 (carry-out of MSB without overflow).
- out_ready held low 5 cycles in DONE, with in_valid pulsed and inputs changed -> s, v and out_valid stable; in_ready=0; the pulsed request is not accepted.
- rst asserted mid-BUSY (idx=2), asynchronously between edges -> out_valid=0, s=0, v=0, in_ready=1 immediately. The next request then completes with a correct result.

Source files
------------

// File: rtl/au_add_mp_pkg.sv
// rtl/au_add_mp_pkg.sv - shared types, index sizing and parameter legality for the sequenced adder
package au_add_mp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MIN_WIDTH = 1;
    localparam int MIN_NWORD = 2;
    localparam int MIN_ARCH  = 0;
    localparam int MAX_ARCH  = 2;

    function automatic int idx_w(input int nword);
        return (nword <= 2) ? 1 : $clog2(nword);
    endfunction

    function automatic bit params_ok(input int width, input int nword, input int arch);
        return (width >= MIN_WIDTH) && (nword >= MIN_NWORD) &&
               (arch >= MIN_ARCH) && (arch <= MAX_ARCH);
    endfunction

endpackage

// File: rtl/au_add_mp_slice.sv
// rtl/au_add_mp_slice.sv - combinational parallel-prefix slice adder
// ARCH: 0 Kogge-Stone, 1 Sklansky, 2 Brent-Kung.
module au_add_mp_slice #(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             v
);

    localparam int LV = $clog2(WIDTH);

    logic [WIDTH-1:0] hx;
    logic [WIDTH-1:0] gg;
    logic [WIDTH-1:0] pp;
    logic [WIDTH:0]   c;

    // Prefix networks are evaluated in place; each level's update order only
    // reads nodes that the same level does not modify.
    always_comb begin
        hx = a ^ b;
        gg = a & b;
        pp = a ^ b;
        if (ARCH == 0) begin
            for (int l = 0; l < LV; l++) begin
                for (int i = WIDTH - 1; i >= (1 << l); i--) begin
                    gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                    pp[i] = pp[i] & pp[i - (1 << l)];
                end
            end
        end else if (ARCH == 1) begin
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        gg[i] = gg[i] | (pp[i] & gg[((i >> l) << l) - 1]);
                        pp[i] = pp[i] & pp[((i >> l) << l) - 1];
                    end
                end
            end
        end else begin
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i + 1) % (2 << l) == 0) begin
                        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                        pp[i] = pp[i] & pp[i - (1 << l)];
                    end
                end
            end
            for (int l = LV - 2; l >= 0; l--) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i + 1) % (2 << l) == (1 << l)) && (i >= (2 << l))) begin
                        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
                        pp[i] = pp[i] & pp[i - (1 << l)];
                    end
                end
            end
        end
        c = {gg | (pp & {WIDTH{ci}}), ci};
    end

    assign s  = hx ^ c[WIDTH-1:0];
    assign co = c[WIDTH];
    assign v  = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/au_add_mp_seq.sv
// rtl/au_add_mp_seq.sv - multi-precision adder, one slice per cycle, LS slice first
// Optional saturation of the result on overflow: AU_ADD_MP_SEQ_SAT_EN.
module au_add_mp_seq
    import au_add_mp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NWORD = 4,
    parameter int ARCH  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NWORD*WIDTH-1:0] a,
    input  logic [NWORD*WIDTH-1:0] b,
    input  logic                   ci,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NWORD*WIDTH-1:0] s,
    output logic                   v
);

    localparam int N  = NWORD * WIDTH;
    localparam int IW = idx_w(NWORD);
    localparam logic [IW-1:0] LAST = IW'(NWORD - 1);

    if (!params_ok(WIDTH, NWORD, ARCH)) begin : g_param_err
        $error("au_add_mp_seq: illegal WIDTH/NWORD/ARCH parameter");
    end

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   acc;
    logic [WIDTH-1:0] sl_s;
    logic           sl_co;
    logic           sl_v;
    logic [N-1:0]   sum_w;
    logic [N-1:0]   res_w;

    // Operands shift down one slice per BUSY cycle, so the slice always sees
    // the low word; the partial sum shifts in from the top.
    au_add_mp_slice #(
        .WIDTH(WIDTH),
        .ARCH (ARCH)
    ) u_slice (
        .a (a_q[WIDTH-1:0]),
        .b (b_q[WIDTH-1:0]),
        .ci(carry),
        .s (sl_s),
        .co(sl_co),
        .v (sl_v)
    );

    assign sum_w = {sl_s, acc[N-1:WIDTH]};

`ifdef AU_ADD_MP_SEQ_SAT_EN
    // On the last slice a_q[WIDTH-1] is the MSB of the latched augend.
    assign res_w = !sl_v ? sum_w :
                   (a_q[WIDTH-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}});
`else
    assign res_w = sum_w;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            v         <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= ci;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q   <= a_q >> WIDTH;
                    b_q   <= b_q >> WIDTH;
                    acc   <= sum_w;
                    carry <= sl_co;
                    if (idx == LAST) begin
                        idx       <= '0;
                        s         <= res_w;
                        v         <= sl_v;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
